// File: rtl/freqdiv_prog_if.sv
// freqdiv_prog_if: control and output bundle for the programmable clock divider.
//   en[NCH]        per-channel count enable
//   mode[NCH]      per-channel output mode (0 = toggle clock, 1 = pulse)
//   div_wr[NCH]    per-channel divisor write strobe
//   div_val[CNT_W] divisor value shared by all channels
//   sync_restart   phase realignment of every channel
//   clk_out[NCH]   divided output per channel
//   tick[NCH]      one-cycle strobe at each terminal count
//   div_pend[NCH]  written divisor waiting for the next terminal count
// master = controller side, slave = divider side.
interface freqdiv_prog_if #(
    parameter int CNT_W = 27,
    parameter int NCH   = 2
);
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   mode;
    logic [NCH-1:0]   div_wr;
    logic [CNT_W-1:0] div_val;
    logic             sync_restart;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   div_pend;

    modport master (
        output en, mode, div_wr, div_val, sync_restart,
        input  clk_out, tick, div_pend
    );

    modport slave (
        input  en, mode, div_wr, div_val, sync_restart,
        output clk_out, tick, div_pend
    );
endinterface

// File: rtl/freqdiv_prog.sv
// freqdiv_prog: runtime-programmable multi-channel clock divider / tick generator.
// Each channel counts q from 0 up to its active divisor dv; the edge where
// q == dv (while enabled) is the terminal edge. Divisor writes during an
// enabled, non-terminal edge are parked in a shadow register and applied at
// the next terminal edge so the running period is never cut short.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    freqdiv_prog_if slave modport (controls in, clk_out/tick/div_pend out)
module freqdiv_prog #(
    parameter int CNT_W       = 27,
    parameter int NCH         = 2,
    parameter int DEFAULT_DIV = 17500000
) (
    input  logic          clk,
    input  logic          rst_n,
    freqdiv_prog_if.slave bus
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NCH-1:0] co_v;
    logic [NCH-1:0] tk_v;
    logic [NCH-1:0] pend_v;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] q;
        logic [CNT_W-1:0] dv;
        logic [CNT_W-1:0] sh;
        logic             pend;
        logic             co;
        logic             tk;
        logic             term;

        assign term = bus.en[i] && (q == dv);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q    <= '0;
                dv   <= DIV_RST;
                sh   <= DIV_RST;
                pend <= 1'b0;
                co   <= 1'b0;
                tk   <= 1'b0;
            end else if (bus.sync_restart) begin
                q  <= '0;
                co <= 1'b0;
                tk <= 1'b0;
                // A same-cycle write supersedes any parked value.
                if (bus.div_wr[i]) begin
                    dv   <= bus.div_val;
                    pend <= 1'b0;
                end else if (pend) begin
                    dv   <= sh;
                    pend <= 1'b0;
                end
            end else if (!bus.en[i]) begin
                tk <= 1'b0;
                if (bus.mode[i]) begin
                    co <= 1'b0;
                end
                // Idle channel: apply immediately and restart the count so
                // q can never sit above the new divisor.
                if (bus.div_wr[i]) begin
                    dv   <= bus.div_val;
                    q    <= '0;
                    pend <= 1'b0;
                end
            end else if (term) begin
                q  <= '0;
                tk <= 1'b1;
                co <= bus.mode[i] ? 1'b1 : ~co;
                if (bus.div_wr[i]) begin
                    dv   <= bus.div_val;
                    pend <= 1'b0;
                end else if (pend) begin
                    dv   <= sh;
                    pend <= 1'b0;
                end
            end else begin
                q  <= q + ONE;
                tk <= 1'b0;
                if (bus.mode[i]) begin
                    co <= 1'b0;
                end
                if (bus.div_wr[i]) begin
                    sh   <= bus.div_val;
                    pend <= 1'b1;
                end
            end
        end

        assign co_v[i]   = co;
        assign tk_v[i]   = tk;
        assign pend_v[i] = pend;
    end

    assign bus.clk_out  = co_v;
    assign bus.tick     = tk_v;
    assign bus.div_pend = pend_v;
endmodule

// File: tb/tb_freqdiv_prog.sv
module tb_freqdiv_prog;
    localparam int CNT_W = 8;
    localparam int NCH   = 2;

    typedef struct packed {
        logic [1:0] co;
        logic [1:0] tk;
        logic [1:0] pd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    freqdiv_prog_if #(.CNT_W(CNT_W), .NCH(NCH)) bus ();

    freqdiv_prog #(.CNT_W(CNT_W), .NCH(NCH), .DEFAULT_DIV(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] en, input logic [1:0] mode,
                         input logic [1:0] wr, input logic [7:0] val,
                         input logic sr);
        bus.en = en;
        bus.mode = mode;
        bus.div_wr = wr;
        bus.div_val = val;
        bus.sync_restart = sr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            rst_n = 1'b0;
            drive(2'b11, 2'b01, 2'b11, 8'd9, 1'b0);
            e = '0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL reset k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    task automatic test_toggle();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            drive(2'b01, 2'b00, 2'b00, 8'd0, 1'b0);
            e = '0;
            e.tk[0] = (k % 4) == 0;
            e.co[0] = ((k / 4) % 2) == 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL toggle k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    task automatic test_pulse();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drive(2'b01, 2'b01, 2'b00, 8'd0, 1'b0);
            e = '0;
            e.tk[0] = (k % 4) == 0;
            e.co[0] = (k % 4) == 0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL pulse k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    // Write 5 at q=1 (edge 6): old period ends at edge 8, then ticks every 6.
    task automatic test_pending();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            drive(2'b01, 2'b01, (k == 6) ? 2'b01 : 2'b00, 8'd5, 1'b0);
            e = '0;
            e.tk[0] = (k == 4) || (k == 8) || (k == 14) || (k == 20);
            e.co[0] = e.tk[0];
            e.pd[0] = (k == 6) || (k == 7);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL pending k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    // Two writes while pending (last wins: 2), then a write of 4 on a terminal edge.
    task automatic test_back_to_back();
        exp_t e;
        logic [1:0] wr;
        logic [7:0] val;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            wr  = (k == 6 || k == 7 || k == 14) ? 2'b01 : 2'b00;
            val = (k == 6) ? 8'd9 : (k == 7) ? 8'd2 : 8'd4;
            drive(2'b01, 2'b01, wr, val, 1'b0);
            e = '0;
            e.tk[0] = (k == 4) || (k == 8) || (k == 11) || (k == 14) || (k == 19);
            e.co[0] = e.tk[0];
            e.pd[0] = (k == 6) || (k == 7);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL back_to_back k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    // Idle write of 0, then enable: toggle every cycle, then pulse mode stays high.
    task automatic test_div_zero();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)
                drive(2'b00, 2'b00, 2'b01, 8'd0, 1'b0);
            else
                drive(2'b01, (k >= 10) ? 2'b01 : 2'b00, 2'b00, 8'd0, 1'b0);
            e = '0;
            if (k >= 2) begin
                e.tk[0] = 1'b1;
                e.co[0] = (k >= 10) ? 1'b1 : ((k % 2) == 0);
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL div_zero k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    // ch1 starts two edges after ch0; restart at edge 8 aligns them.
    task automatic test_sync_restart();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive((k <= 2) ? 2'b01 : 2'b11, 2'b00, 2'b00, 8'd0, k == 8);
            e = '0;
            if (k < 8) begin
                e.tk[0] = (k == 4);
                e.co[0] = (k >= 4);
                e.tk[1] = (k == 6);
                e.co[1] = (k >= 6);
            end else if (k > 8) begin
                e.tk = ((k - 8) % 4 == 0) ? 2'b11 : 2'b00;
                e.co = (((k - 8) / 4) % 2 == 1) ? 2'b11 : 2'b00;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL sync_restart k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
    endtask

    // Reset while pending and writing: divisor returns to 3, write dropped.
    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            rst_n = (k != 7);
            drive(2'b01, 2'b01, (k == 6 || k == 7) ? 2'b01 : 2'b00,
                  (k == 6) ? 8'd5 : 8'd7, 1'b0);
            e = '0;
            e.tk[0] = (k == 4) || (k == 11) || (k == 15);
            e.co[0] = e.tk[0];
            e.pd[0] = (k == 6);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.div_pend} !== {e.co, e.tk, e.pd}) begin
                errors++;
                $display("FAIL reset_mid k=%0d got co=%b tk=%b pd=%b exp co=%b tk=%b pd=%b",
                         k, bus.clk_out, bus.tick, bus.div_pend, e.co, e.tk, e.pd);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 8'd0, 1'b0);
        test_reset();
        test_toggle();
        test_pulse();
        test_pending();
        test_back_to_back();
        test_div_zero();
        test_sync_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freqdiv_prog.md
Name: freqdiv_prog

Overview:
Parametrised, runtime-programmable multi-channel clock divider and tick generator for the speaker datapath. It replaces the fixed single-rate dividers: each channel divides the system clock by a software-loadable terminal count. Each channel produces either a 50% toggle clock or a one-cycle strobe. Divisor changes are glitch-free: a new value takes effect only at a period boundary, unless the channel is idle.

Parameters:
CNT_W, 27, width of counters and divisor values
NCH, 2, number of independent divider channels
DEFAULT_DIV, 17500000, terminal count loaded at reset into every channel (must fit in CNT_W)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
en  in  NCH  per-channel count enable
mode  in  NCH  per-channel output mode: 0 = toggle clock, 1 = pulse
div_wr  in  NCH  per-channel divisor write strobe, one cycle
div_val  in  CNT_W  divisor value, shared by all channels, captured on div_wr
sync_restart  in  1  realigns the phase of all channels
clk_out  out  NCH  divided output per channel (toggle or pulse, per mode)
tick  out  NCH  one-cycle strobe at each terminal count
div_pend  out  NCH  a written divisor is waiting for the next terminal count

Behaviour:
- Per-channel state: counter q, active divisor dv, shadow sh, flag pend. All outputs are registered.
- Priority per edge: rst_n=0 > sync_restart > div_wr > normal counting.
- Reset (rst_n=0 at posedge): q=0, dv=sh=DEFAULT_DIV, pend=0, clk_out=0, tick=0, div_pend=0. Concurrent div_wr is ignored.
- Terminal condition: en[i]=1 and q==dv.
- Normal count, en[i]=1, not terminal: q<=q+1, tick<=0. In mode 0, clk_out holds. In mode 1, clk_out<=0.
- Terminal edge:
  - q<=0, tick<=1 for exactly one cycle.
  - Mode 0: clk_out toggles, so the period is 2*(dv+1) cycles at 50% duty.
  - Mode 1: clk_out<=1 for one cycle, giving one pulse every dv+1 cycles.
  - If pend=1: dv<=sh, pend<=0.
- en[i]=0: q, clk_out, dv and pend hold; tick<=0; clk_out in mode 1 <=0. When en rises, counting resumes from the held q.
- div_wr[i] with en[i]=1, non-terminal edge: sh<=div_val, pend<=1. dv is unchanged, so the current period completes with the old value.
- div_wr[i] with en[i]=1 on a terminal edge: dv<=div_val directly and pend<=0. The write wins over any older pending value, and the next period uses the new value.
- div_wr[i] with en[i]=0: dv<=div_val, q<=0, pend<=0 immediately. This guarantees q<=dv always.
- Repeated writes while pend=1: the last value written wins.
- div_pend = pend.
- dv=0 is legal:
  - Terminal fires every enabled cycle.
  - Mode 0: clk_out = clk/2.
  - Mode 1: clk_out and tick stay continuously 1.
- sync_restart: all channels q<=0, clk_out<=0, tick<=0. Any pending sh is applied (dv<=sh, pend<=0). A div_wr in the same cycle loads div_val into dv directly.
- Latency: after reset release with en=1 and dv=D, the first tick is high in the cycle following the (D+1)th enabled edge.
- Wrap-around: q never exceeds dv, so no overflow is possible for any CNT_W.
- Channels are fully independent except for the shared div_val and sync_restart.

Test Plan:
- Bench parameters for all scenarios: CNT_W=8, NCH=2, DEFAULT_DIV=3.
- Release reset, en=2'b01, mode=0 -> ch0 clk_out toggles every 4 cycles (period 8); tick0 one cycle every 4; ch1 all outputs 0.
- Mode=1 on ch0, en=1 -> clk_out0 == tick0, single-cycle pulse every 4 cycles, first pulse 4 edges after reset release.
- Ch0 running D=3; at q=1 assert div_wr0 with div_val=5 -> div_pend0 high until the old terminal (2 edges later); that tick still occurs 4 cycles after the previous one; subsequent ticks every 6 cycles; div_pend0 clears.
- en0=0, div_wr0 with div_val=0, then en0=1 in mode 0 -> clk_out0 toggles every cycle; div_pend0 never asserts.
- Ch0 D=3 and ch1 D=3 running out of phase; pulse sync_restart -> both q=0, both clk_out=0; thereafter tick0 and tick1 coincide every 4 cycles.
- Mid-operation, with pend=1 and div_wr asserted, hold rst_n=0 for one edge -> all outputs 0, div_pend=0, dv restored to 3 (first tick 4 edges after release); the write is discarded.
